// File: rtl/branch_ctrl.sv
// EX-stage branch resolution controller.
// Decodes funct3 for the comparator and turns less/equal into a taken decision.
// Issues a zero-latency PC redirect and flush, and blocks the wrong-path
// instruction that follows a redirect.
// Keeps counters for resolved branches and branch mispredicts.
// Optional feature macro BRANCH_PREDICT_EN: adds a 2-bit saturating BHT that
// supplies the fetch-stage prediction.
module branch_ctrl #(
    parameter int PC_W        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             br_less,
    input  logic             br_equal,
    input  logic [PC_W-1:0]  if_pc,
    output logic             br_unsigned,
    output logic             if_pred_taken,
    output logic             redirect,
    output logic             redirect_sel,
    output logic             flush,
    output logic             br_illegal,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispred
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] branches_r;
    logic [CNT_W-1:0] mispred_r;

    logic res_s;
    logic taken_s;
    logic illegal_f3_s;
    logic pred_s;
    logic redirect_s;
    logic sel_s;
    logic br_res_s;

    // A 2-bit saturating counter moves one step toward taken or not-taken.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    // Resolution happens only for a live EX slot that is not on the wrong path.
    assign res_s        = ex_valid & ~ex_stall & (state_r == IDLE);
    assign illegal_f3_s = (ex_funct3[2:1] == 2'b01);
    assign br_res_s     = res_s & ex_is_branch & ~ex_is_jump;

    // Combine the comparator flags into the branch condition selected by funct3.
    always_comb begin
        taken_s = 1'b0;
        case (ex_funct3)
            3'b000:  taken_s = br_equal;
            3'b001:  taken_s = ~br_equal;
            3'b100:  taken_s = br_less;
            3'b101:  taken_s = ~br_less;
            3'b110:  taken_s = br_less;
            3'b111:  taken_s = ~br_less;
            default: taken_s = 1'b0;
        endcase
    end

    // A jump always redirects; a branch redirects only when the prediction was wrong.
    always_comb begin
        redirect_s = 1'b0;
        sel_s      = 1'b0;
        if (res_s && ex_is_jump) begin
            redirect_s = 1'b1;
            sel_s      = 1'b0;
        end else if (res_s && ex_is_branch) begin
            redirect_s = (taken_s != pred_s);
            sel_s      = ~taken_s;
        end else begin
            redirect_s = 1'b0;
            sel_s      = 1'b0;
        end
    end

    assign br_unsigned   = ex_funct3[1];
    assign redirect      = redirect_s;
    assign redirect_sel  = sel_s;
    assign flush         = redirect_s;
    assign br_illegal    = res_s & ex_is_branch & illegal_f3_s;
    assign perf_branches = branches_r;
    assign perf_mispred  = mispred_r;

    // Shadow FSM: after a redirect, ignore the one wrong-path instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= redirect_s ? SHADOW : IDLE;
                SHADOW:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Performance counters wrap naturally at their full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_r <= {CNT_W{1'b0}};
            mispred_r  <= {CNT_W{1'b0}};
        end else if (br_res_s) begin
            branches_r <= branches_r + {{(CNT_W-1){1'b0}}, 1'b1};
            mispred_r  <= mispred_r + {{(CNT_W-1){1'b0}}, redirect_s};
        end else begin
            branches_r <= branches_r;
            mispred_r  <= mispred_r;
        end
    end

`ifdef BRANCH_PREDICT_EN
    logic [1:0]       bht_r [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic             unused_s;

    assign if_idx_s      = if_pc[IDX_W+1:2];
    assign ex_idx_s      = ex_pc[IDX_W+1:2];
    assign if_pred_taken = bht_r[if_idx_s][1];
    assign pred_s        = ex_pred_taken;
    assign unused_s      = ^{if_pc, ex_pc};

    // BHT training; the updated entry becomes visible to fetch on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (res_s && ex_is_branch && !illegal_f3_s) begin
            bht_r[ex_idx_s] <= sat_update(bht_r[ex_idx_s], taken_s);
        end else begin
            bht_r[ex_idx_s] <= bht_r[ex_idx_s];
        end
    end
`else
    logic unused_s;

    assign if_pred_taken = 1'b0;
    assign pred_s        = 1'b0;
    assign unused_s      = ^{if_pc, ex_pc, ex_pred_taken, IDX_W[0], sat_update(2'b00, 1'b0)};
`endif

endmodule
